// File: rtl/time_keeper.sv
// time_keeper: binary hours:minutes:seconds counter driven by a prescaled
// 1 Hz tick. It freezes while the time is being edited and loads the
// edited (range-checked) time on the cycle set mode is released.
module time_keeper #(
  parameter int DIV   = 100_000_000,
  parameter int CNT_W = 27
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       en,
  input  logic       set_mod,
  input  logic [5:0] set_hours,
  input  logic [5:0] set_minutes,
  input  logic [5:0] set_seconds,
  output logic [5:0] seconds,
  output logic [5:0] minutes,
  output logic [5:0] hours,
  output logic       tick_1hz,
  output logic       hour_strobe,
  output logic       day_wrap
);

  localparam logic [CNT_W-1:0] DivLast = CNT_W'(DIV - 1);

  logic [CNT_W-1:0] prescaler_q, prescaler_d;
  logic [5:0]       seconds_q, seconds_d;
  logic [5:0]       minutes_q, minutes_d;
  logic [5:0]       hours_q, hours_d;
  logic             tick_q, tick_d;
  logic             hourStrobe_q, hourStrobe_d;
  logic             dayWrap_q, dayWrap_d;
  logic             setModDly_q, setModDly_d;
  logic             loadEvent;

  // A load happens on the first cycle set_mod is seen low after being high.
  assign loadEvent = setModDly_q & ~set_mod;

  // Next-state: load > set hold > enable hold > count/advance.
  always_comb begin
    prescaler_d  = prescaler_q;
    seconds_d    = seconds_q;
    minutes_d    = minutes_q;
    hours_d      = hours_q;
    tick_d       = 1'b0;
    hourStrobe_d = 1'b0;
    dayWrap_d    = 1'b0;
    setModDly_d  = set_mod;

    if (loadEvent) begin
      prescaler_d = '0;
      seconds_d   = (set_seconds <= 6'd59) ? set_seconds : 6'd0;
      minutes_d   = (set_minutes <= 6'd59) ? set_minutes : 6'd0;
      hours_d     = (set_hours   <= 6'd23) ? set_hours   : 6'd0;
    end else if (set_mod) begin
      prescaler_d = '0;
    end else if (en) begin
      if (prescaler_q == DivLast) begin
        prescaler_d = '0;
        tick_d      = 1'b1;
        if (seconds_q == 6'd59) begin
          seconds_d = 6'd0;
          if (minutes_q == 6'd59) begin
            minutes_d    = 6'd0;
            hourStrobe_d = 1'b1;
            if (hours_q == 6'd23) begin
              hours_d   = 6'd0;
              dayWrap_d = 1'b1;
            end else begin
              hours_d = hours_q + 6'd1;
            end
          end else begin
            minutes_d = minutes_q + 6'd1;
          end
        end else begin
          seconds_d = seconds_q + 6'd1;
        end
      end else begin
        prescaler_d = prescaler_q + CNT_W'(1);
      end
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      prescaler_q  <= '0;
      seconds_q    <= 6'd0;
      minutes_q    <= 6'd0;
      hours_q      <= 6'd0;
      tick_q       <= 1'b0;
      hourStrobe_q <= 1'b0;
      dayWrap_q    <= 1'b0;
      setModDly_q  <= 1'b0;
    end else begin
      prescaler_q  <= prescaler_d;
      seconds_q    <= seconds_d;
      minutes_q    <= minutes_d;
      hours_q      <= hours_d;
      tick_q       <= tick_d;
      hourStrobe_q <= hourStrobe_d;
      dayWrap_q    <= dayWrap_d;
      setModDly_q  <= setModDly_d;
    end
  end

  assign seconds     = seconds_q;
  assign minutes     = minutes_q;
  assign hours       = hours_q;
  assign tick_1hz    = tick_q;
  assign hour_strobe = hourStrobe_q;
  assign day_wrap    = dayWrap_q;

endmodule

// File: tb/tb_time_keeper.sv
// Testbench for time_keeper with DIV=4: a cycle-by-cycle vector table
// plus hand-written sequences for load latency and pause behaviour.
module tb_time_keeper;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       en = 1'b0;
  logic       setMod = 1'b0;
  logic [5:0] setHours = 6'd0;
  logic [5:0] setMinutes = 6'd0;
  logic [5:0] setSeconds = 6'd0;
  logic [5:0] seconds, minutes, hours;
  logic       tick1hz, hourStrobe, dayWrap;

  int testsRun = 0;
  int testsFailed = 0;

  time_keeper #(.DIV(4), .CNT_W(3)) dut (
    .clk        (clk),
    .reset      (reset),
    .en         (en),
    .set_mod    (setMod),
    .set_hours  (setHours),
    .set_minutes(setMinutes),
    .set_seconds(setSeconds),
    .seconds    (seconds),
    .minutes    (minutes),
    .hours      (hours),
    .tick_1hz   (tick1hz),
    .hour_strobe(hourStrobe),
    .day_wrap   (dayWrap)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       rst;
    logic       en;
    logic       sm;
    logic [5:0] sh, smin, ss;
    logic [5:0] eh, em, es;
    logic       et, ehs, edw;
  } vec_t;

  vec_t vecs[$];

  task automatic addVec(input logic r, input logic e, input logic s,
                        input int h, input int m, input int sec,
                        input int eh, input int em, input int es,
                        input logic t, input logic hs, input logic dw);
    vec_t v;
    v.rst = r; v.en = e; v.sm = s;
    v.sh = 6'(h); v.smin = 6'(m); v.ss = 6'(sec);
    v.eh = 6'(eh); v.em = 6'(em); v.es = 6'(sec == -1 ? 0 : es);
    v.et = t; v.ehs = hs; v.edw = dw;
    vecs.push_back(v);
  endtask

  // One clock with the vector's inputs, then sample 1 time unit later.
  task automatic applyStimulus(input vec_t v);
    reset = v.rst; en = v.en; setMod = v.sm;
    setHours = v.sh; setMinutes = v.smin; setSeconds = v.ss;
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input vec_t v);
    logic [20:0] got, exp;
    got = {hours, minutes, seconds, tick1hz, hourStrobe, dayWrap};
    exp = {v.eh, v.em, v.es, v.et, v.ehs, v.edw};
    testsRun++;
    if (got !== exp) begin
      testsFailed++;
      $display("[TB] FAIL %s: got %0d:%0d:%0d t=%b hs=%b dw=%b, expected %0d:%0d:%0d t=%b hs=%b dw=%b",
               name, hours, minutes, seconds, tick1hz, hourStrobe, dayWrap,
               v.eh, v.em, v.es, v.et, v.ehs, v.edw);
    end
  endtask

  task automatic checkVal(input string name, input int got, input int exp);
    testsRun++;
    if (got != exp) begin
      testsFailed++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int cycles;
    int ticks;

    // Reset, then 8 running cycles: advances on the 4th and 8th edges.
    addVec(1,0,0, 0,0,0,  0,0,0, 0,0,0);
    addVec(0,1,0, 0,0,0,  0,0,0, 0,0,0);
    addVec(0,1,0, 0,0,0,  0,0,0, 0,0,0);
    addVec(0,1,0, 0,0,0,  0,0,0, 0,0,0);
    addVec(0,1,0, 0,0,0,  0,0,1, 1,0,0);
    addVec(0,1,0, 0,0,0,  0,0,1, 0,0,0);
    addVec(0,1,0, 0,0,0,  0,0,1, 0,0,0);
    addVec(0,1,0, 0,0,0,  0,0,1, 0,0,0);
    addVec(0,1,0, 0,0,0,  0,0,2, 1,0,0);
    // Set mode 10 cycles with 12:34:56: frozen, then load, then :57 4 edges later.
    for (int i = 0; i < 10; i++) addVec(0,1,1, 12,34,56, 0,0,2, 0,0,0);
    addVec(0,1,0, 12,34,56, 12,34,56, 0,0,0);
    addVec(0,1,0, 0,0,0,    12,34,56, 0,0,0);
    addVec(0,1,0, 0,0,0,    12,34,56, 0,0,0);
    addVec(0,1,0, 0,0,0,    12,34,56, 0,0,0);
    addVec(0,1,0, 0,0,0,    12,34,57, 1,0,0);
    // 23:59:59 -> 00:00:00 with all three pulses in one cycle.
    addVec(0,1,1, 23,59,59, 12,34,57, 0,0,0);
    addVec(0,1,0, 23,59,59, 23,59,59, 0,0,0);
    addVec(0,1,0, 0,0,0,    23,59,59, 0,0,0);
    addVec(0,1,0, 0,0,0,    23,59,59, 0,0,0);
    addVec(0,1,0, 0,0,0,    23,59,59, 0,0,0);
    addVec(0,1,0, 0,0,0,    0,0,0,    1,1,1);
    addVec(0,1,0, 0,0,0,    0,0,0,    0,0,0);
    // 05:59:59 -> 06:00:00: hour strobe only.
    addVec(0,1,1, 5,59,59,  0,0,0,    0,0,0);
    addVec(0,1,0, 5,59,59,  5,59,59,  0,0,0);
    addVec(0,1,0, 0,0,0,    5,59,59,  0,0,0);
    addVec(0,1,0, 0,0,0,    5,59,59,  0,0,0);
    addVec(0,1,0, 0,0,0,    5,59,59,  0,0,0);
    addVec(0,1,0, 0,0,0,    6,0,0,    1,1,0);
    // 05:58:59 -> 05:59:00: minute carry without hour strobe.
    addVec(0,1,1, 5,58,59,  6,0,0,    0,0,0);
    addVec(0,1,0, 5,58,59,  5,58,59,  0,0,0);
    addVec(0,1,0, 0,0,0,    5,58,59,  0,0,0);
    addVec(0,1,0, 0,0,0,    5,58,59,  0,0,0);
    addVec(0,1,0, 0,0,0,    5,58,59,  0,0,0);
    addVec(0,1,0, 0,0,0,    5,59,0,   1,0,0);
    // Out-of-range load (30/60/63) clamps every field to zero.
    addVec(0,1,1, 30,60,63, 5,59,0,   0,0,0);
    addVec(0,1,0, 30,60,63, 0,0,0,    0,0,0);
    // Two running cycles, pause 20, resume: advance on 2nd running edge.
    addVec(0,1,0, 0,0,0,    0,0,0,    0,0,0);
    addVec(0,1,0, 0,0,0,    0,0,0,    0,0,0);
    for (int i = 0; i < 20; i++) addVec(0,0,0, 0,0,0, 0,0,0, 0,0,0);
    addVec(0,1,0, 0,0,0,    0,0,0,    0,0,0);
    addVec(0,1,0, 0,0,0,    0,0,1,    1,0,0);
    // Reset mid-count loses the prescaler phase.
    addVec(0,1,0, 0,0,0,    0,0,1,    0,0,0);
    addVec(0,1,0, 0,0,0,    0,0,1,    0,0,0);
    addVec(1,1,0, 0,0,0,    0,0,0,    0,0,0);
    addVec(0,1,0, 0,0,0,    0,0,0,    0,0,0);
    addVec(0,1,0, 0,0,0,    0,0,0,    0,0,0);
    addVec(0,1,0, 0,0,0,    0,0,0,    0,0,0);
    addVec(0,1,0, 0,0,0,    0,0,1,    1,0,0);
    // Reset while set_mod high: a later release still loads.
    addVec(1,1,1, 7,8,9,    0,0,0,    0,0,0);
    addVec(0,1,1, 7,8,9,    0,0,0,    0,0,0);
    addVec(0,1,0, 7,8,9,    7,8,9,    0,0,0);

    for (int i = 0; i < vecs.size(); i++) begin
      applyStimulus(vecs[i]);
      checkOutput($sformatf("vec%0d", i), vecs[i]);
    end

    // Load 00:00:10 and measure cycles to the first tick (bounded).
    reset = 0; en = 1; setMod = 1;
    setHours = 6'd0; setMinutes = 6'd0; setSeconds = 6'd10;
    step();
    setMod = 0;
    step();
    checkVal("load_seconds", int'(seconds), 10);
    cycles = 0;
    while (!tick1hz && cycles < 20) begin
      step();
      cycles++;
    end
    checkVal("load_to_tick_cycles", cycles, 4);
    checkVal("tick_seconds", int'(seconds), 11);
    step();
    checkVal("tick_width", int'(tick1hz), 0);

    // Long pause: no ticks and no time change over 40 cycles.
    en = 0;
    ticks = 0;
    for (int i = 0; i < 40; i++) begin
      step();
      if (tick1hz) ticks++;
    end
    checkVal("pause_ticks", ticks, 0);
    checkVal("pause_seconds", int'(seconds), 11);

    // Run 12 seconds' worth: exactly 3 single-cycle ticks.
    en = 1;
    ticks = 0;
    for (int i = 0; i < 12; i++) begin
      step();
      if (tick1hz) ticks++;
    end
    checkVal("run_ticks", ticks, 3);
    checkVal("run_seconds", int'(seconds), 14);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule

// File: doc/time_keeper.md
Name: time_keeper

Overview:
Free-running time-of-day counter for the clock design. It divides the 100 MHz system clock down to a 1 Hz tick and advances hours:minutes:seconds in binary. It freezes while the setting stage is active and loads the edited time when set mode is left. Its seconds/minutes/hours outputs feed the setting stage's source-time inputs and the display path.

Parameters:
DIV, 100_000_000, clk cycles per second tick; must be at least 2; the bench uses 4.
CNT_W, 27, prescaler width; must satisfy 2^CNT_W >= DIV.

Ports:
clk  input  1  system clock, 100 MHz.
reset  input  1  synchronous, active-high reset.
en  input  1  run enable; low pauses timekeeping.
set_mod  input  1  high while the user is editing the time.
set_hours  input  6  edited hours; integration passes the low 6 bits of the setting stage output.
set_minutes  input  6  edited minutes.
set_seconds  input  6  edited seconds.
seconds  output  6  current seconds, 0..59.
minutes  output  6  current minutes, 0..59.
hours  output  6  current hours, 0..23.
tick_1hz  output  1  one-cycle pulse, high in the cycle after each seconds advance.
hour_strobe  output  1  one-cycle pulse when minutes and seconds wrap together (XX:59:59 -> XX+1:00:00).
day_wrap  output  1  one-cycle pulse on the 23:59:59 -> 00:00:00 transition.

Behaviour:
- All state is updated on posedge clk only. There is no asynchronous logic.
- Reset, synchronous and highest priority:
  - seconds = minutes = hours = 0.
  - Prescaler = 0.
  - tick_1hz = hour_strobe = day_wrap = 0.
  - set_mod_d (registered copy of set_mod) = 0.
- set_mod_d <= set_mod every non-reset cycle.
- Load event = set_mod_d & ~set_mod, i.e. the first cycle with set_mod low after it was high.
- On a load event:
  - seconds <= set_seconds if set_seconds <= 59, else 0.
  - minutes <= set_minutes if set_minutes <= 59, else 0.
  - hours <= set_hours if set_hours <= 23, else 0.
  - Prescaler <= 0.
  - All pulses 0 that cycle.
  - Load occurs regardless of en.
- While set_mod = 1:
  - Prescaler is held at 0 and the time is held.
  - No pulses are generated.
- While en = 0 (and no load event):
  - Prescaler and time are held, no pulses.
  - Prescaler resumes from its held value when en returns high.
- Running (en = 1, set_mod = 0, no load event):
  - If prescaler < DIV-1: prescaler increments.
  - If prescaler == DIV-1: prescaler <= 0 and the time advances on this same edge.
- Advance rules, applied in one cycle:
  - seconds 59 -> 0 with minute carry.
  - minutes 59 -> 0 with hour carry.
  - hours 23 -> 0.
- Pulse registers, set on the advancing edge so they are high during the first cycle the new time is visible:
  - tick_1hz = 1 on every advance.
  - hour_strobe = 1 when the advance wraps seconds and minutes.
  - day_wrap = 1 when the advance wraps hours 23 -> 0.
  - All pulses return to 0 the next cycle.
- Latency: after a load event, the first advance occurs on the DIV-th running edge. The first tick_1hz is visible DIV cycles after the load cycle.
- Priority, highest first: reset > load event > set_mod hold > en hold > count.
- Reset mid-count: the prescaler phase is lost and counting restarts from 0.
- Reset while set_mod is high: set_mod_d is 1 one cycle later. A later set_mod fall then loads the set_* values.
- Outputs are never outside their stated ranges in any cycle.

Test Plan:
- DIV=4, reset then en=1, 8 cycles -> seconds 0->1 on the 4th edge and 1->2 on the 8th; tick_1hz high exactly 2 cycles total, each 1 cycle wide.
- set_mod=1 for 10 cycles with set_* = 12/34/56, then set_mod=0 -> time frozen during set; hours=12, minutes=34, seconds=56 the cycle after the fall; next advance to :57 exactly 4 cycles later.
- Load 23:59:59 and run one second -> 00:00:00; tick_1hz, hour_strobe and day_wrap all high the same single cycle.
- Load 05:59:59 -> 06:00:00 with hour_strobe=1 and day_wrap=0. Then load 05:58:59 -> 05:59:00 with hour_strobe=0.
- Load out-of-range values set_hours=30, set_minutes=60, set_seconds=63 -> 00:00:00 loaded, no pulses.
- en=0 after 2 running cycles, hold 20 cycles, then en=1 -> no advance while paused; advance occurs 2 running cycles after resume. Assert reset mid-count -> all outputs 0 next cycle.
